// File: rtl/uart_rx_if.sv
// Serial receive bus: the raw line and baud-generator handshake going in,
// the received word and its status strobes coming out.
interface uart_rx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  rs232_rx;
  logic                  bps_clk;
  logic                  bps_en;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_done;
  logic                  rx_err;

  // Environment side: drives the line and the baud tick, observes results.
  modport master (
    output rs232_rx,
    output bps_clk,
    input  bps_en,
    input  rx_data,
    input  rx_done,
    input  rx_err
  );

  // Receiver side.
  modport slave (
    input  rs232_rx,
    input  bps_clk,
    output bps_en,
    output rx_data,
    output rx_done,
    output rx_err
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: synchronizes the serial line, detects the start edge,
// requests mid-bit ticks from an external baud generator and assembles
// an LSB-first frame of DATA_WIDTH data bits followed by one stop bit.
module uart_rx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 2);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_WIDTH);

  typedef enum logic {
    IDLE,
    RECV
  } state_t;

  logic rx_p0;
  logic rx_p1;
  logic rx_p2;
  logic fall;

  state_t                state;
  state_t                state_next;
  logic                  bps_en;
  logic                  bps_en_next;
  logic [CNT_W-1:0]      bit_cnt;
  logic [CNT_W-1:0]      bit_cnt_next;
  logic [DATA_WIDTH-1:0] shift;
  logic [DATA_WIDTH-1:0] shift_next;
  logic [DATA_WIDTH-1:0] rx_data;
  logic [DATA_WIDTH-1:0] rx_data_next;
  logic                  rx_done;
  logic                  rx_done_next;
  logic                  rx_err;
  logic                  rx_err_next;

  // Two-flop synchronizer (p0, p1) plus a history flop (p2) for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
      rx_p2 <= 1'b1;
    end else begin
      rx_p0 <= bus.rs232_rx;
      rx_p1 <= rx_p0;
      rx_p2 <= rx_p1;
    end
  end

  // Start-of-frame candidate: previous synchronized sample high, current low.
  assign fall = rx_p2 & ~rx_p1;

  // State, counter, shift register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      bps_en  <= 1'b0;
      bit_cnt <= '0;
      shift   <= '0;
      rx_data <= '0;
      rx_done <= 1'b0;
      rx_err  <= 1'b0;
    end else begin
      state   <= state_next;
      bps_en  <= bps_en_next;
      bit_cnt <= bit_cnt_next;
      shift   <= shift_next;
      rx_data <= rx_data_next;
      rx_done <= rx_done_next;
      rx_err  <= rx_err_next;
    end
  end

  // Frame sequencing: tick 0 validates the start bit, ticks 1..DATA_WIDTH
  // shift data in LSB first, the final tick checks the stop bit.
  always_comb begin
    state_next   = state;
    bps_en_next  = bps_en;
    bit_cnt_next = bit_cnt;
    shift_next   = shift;
    rx_data_next = rx_data;
    rx_done_next = 1'b0;
    rx_err_next  = 1'b0;
    unique case (state)
      IDLE: begin
        // Baud ticks are ignored here; only a falling edge starts a frame.
        if (fall) begin
          state_next   = RECV;
          bps_en_next  = 1'b1;
          bit_cnt_next = '0;
        end
      end
      RECV: begin
        // Falling edges inside the frame are data transitions, not starts.
        if (bus.bps_clk) begin
          if (bit_cnt == '0) begin
            if (rx_p1) begin
              // Line was high at mid start bit: treat as a glitch.
              state_next   = IDLE;
              bps_en_next  = 1'b0;
              bit_cnt_next = '0;
            end else begin
              bit_cnt_next = bit_cnt + CNT_W'(1);
            end
          end else if (bit_cnt <= LAST_DATA) begin
            shift_next   = {rx_p1, shift[DATA_WIDTH-1:1]};
            bit_cnt_next = bit_cnt + CNT_W'(1);
          end else begin
            state_next   = IDLE;
            bps_en_next  = 1'b0;
            bit_cnt_next = '0;
            if (rx_p1) begin
              rx_data_next = shift;
              rx_done_next = 1'b1;
            end else begin
              rx_err_next = 1'b1;
            end
          end
        end
      end
      default: begin
        state_next  = IDLE;
        bps_en_next = 1'b0;
      end
    endcase
  end

  assign bus.bps_en  = bps_en;
  assign bus.rx_data = rx_data;
  assign bus.rx_done = rx_done;
  assign bus.rx_err  = rx_err;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: an 8-bit and a 7-bit receiver share clk/rst,
// each fed by a simple mid-bit baud generator model.
`timescale 1ns/1ps
module tb_uart_rx;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   bit_clks = 1250;

  int n_cmp = 0;
  int n_err = 0;

  always #41.667 clk = ~clk;

  uart_rx_if #(.DATA_WIDTH(8)) bus8 ();
  uart_rx_if #(.DATA_WIDTH(7)) bus7 ();

  uart_rx #(.DATA_WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  uart_rx #(.DATA_WIDTH(7)) dut7 (.clk(clk), .rst(rst), .bus(bus7));

  // Baud generator models: tick at the middle of each bit while enabled.
  int bcnt8 = 0;
  int bcnt7 = 0;
  always @(posedge clk) begin
    if (!bus8.bps_en || bcnt8 == bit_clks - 1) bcnt8 <= 0;
    else bcnt8 <= bcnt8 + 1;
    if (!bus7.bps_en || bcnt7 == bit_clks - 1) bcnt7 <= 0;
    else bcnt7 <= bcnt7 + 1;
  end
  assign bus8.bps_clk = bus8.bps_en && (bcnt8 == bit_clks / 2);
  assign bus7.bps_clk = bus7.bps_en && (bcnt7 == bit_clks / 2);

  // Monitors: event counters and logs, compared by differences.
  int         done8 = 0, err8 = 0, rise8 = 0, run8 = 0, last_run8 = 0;
  int         done7 = 0, err7 = 0, ticks7 = 0, both = 0;
  logic       prev_en8 = 1'b0;
  logic [7:0] dlog8[$];
  always @(posedge clk) begin
    prev_en8 <= bus8.bps_en;
    if (bus8.bps_en && !prev_en8) rise8 <= rise8 + 1;
    if (bus8.bps_en) run8 <= run8 + 1;
    else begin
      if (run8 != 0) last_run8 <= run8;
      run8 <= 0;
    end
    if (bus8.rx_done) begin
      done8 <= done8 + 1;
      dlog8.push_back(bus8.rx_data);
    end
    if (bus8.rx_err) err8 <= err8 + 1;
    if (bus7.rx_done) done7 <= done7 + 1;
    if (bus7.rx_err) err7 <= err7 + 1;
    if (bus7.bps_clk) ticks7 <= ticks7 + 1;
    if ((bus8.rx_done && bus8.rx_err) || (bus7.rx_done && bus7.rx_err)) both <= both + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic b, input bit w7);
    if (w7) bus7.rs232_rx = b;
    else    bus8.rs232_rx = b;
    repeat (bit_clks) @(negedge clk);
  endtask

  task automatic send8(input logic [7:0] d, input logic stop);
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i], 1'b0);
    drive_bit(stop, 1'b0);
    bus8.rs232_rx = 1'b1;
  endtask

  task automatic send7(input logic [6:0] d);
    drive_bit(1'b0, 1'b1);
    for (int i = 0; i < 7; i++) drive_bit(d[i], 1'b1);
    drive_bit(1'b1, 1'b1);
    bus7.rs232_rx = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  int d0, e0, r0, t0, q0;

  initial begin
    bus8.rs232_rx = 1'b1;
    bus7.rs232_rx = 1'b1;
    #1 rst = 1'b1;
    idle(4);
    check("rst_bps_en", bus8.bps_en, 0);
    check("rst_rx_data", bus8.rx_data, 0);
    check("rst_rx_done", bus8.rx_done, 0);
    check("rst_rx_err", bus8.rx_err, 0);
    rst = 1'b0;
    idle(20);

    // Test 1: 0xA5 at 1250 clocks/bit
    bit_clks = 1250;
    d0 = done8; e0 = err8;
    send8(8'hA5, 1'b1);
    idle(2 * bit_clks);
    check("t1_done_cnt", done8 - d0, 1);
    check("t1_err_cnt", err8 - e0, 0);
    check("t1_rx_data", bus8.rx_data, 8'hA5);
    check("t1_bps_en_low", bus8.bps_en, 0);
    check("t1_bps_en_len", (last_run8 >= 9 * 1250 && last_run8 <= 10 * 1250), 1);

    // Test 2: 0x3C with a low stop bit
    bit_clks = 64;
    d0 = done8; e0 = err8;
    send8(8'h3C, 1'b0);
    idle(4 * bit_clks);
    check("t2_err_cnt", err8 - e0, 1);
    check("t2_done_cnt", done8 - d0, 0);
    check("t2_rx_data", bus8.rx_data, 8'hA5);

    // Test 3: 200-clock glitch, start sampled high at mid-bit
    bit_clks = 1250;
    d0 = done8; e0 = err8; r0 = rise8;
    bus8.rs232_rx = 1'b0;
    idle(200);
    bus8.rs232_rx = 1'b1;
    idle(1500);
    check("t3_bps_en_rise", rise8 - r0, 1);
    check("t3_bps_en_low", bus8.bps_en, 0);
    check("t3_bps_en_len", (last_run8 >= 620 && last_run8 <= 640), 1);
    check("t3_done_cnt", done8 - d0, 0);
    check("t3_err_cnt", err8 - e0, 0);

    // Test 4: 0x00 then 0xFF with no idle gap
    bit_clks = 64;
    d0 = done8; q0 = dlog8.size();
    send8(8'h00, 1'b1);
    send8(8'hFF, 1'b1);
    idle(2 * bit_clks);
    check("t4_done_cnt", done8 - d0, 2);
    check("t4_first", (dlog8.size() > q0) ? dlog8[q0] : 8'hxx, 8'h00);
    check("t4_second", (dlog8.size() > q0 + 1) ? dlog8[q0 + 1] : 8'hxx, 8'hFF);

    // Test 5: reset during data bit 4 of 0x55, then 0x81
    d0 = done8; e0 = err8;
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(i[0] ? 1'b0 : 1'b1, 1'b0);
    bus8.rs232_rx = 1'b1;
    idle(bit_clks / 2);
    #10 rst = 1'b1;
    idle(3);
    check("t5_rst_bps_en", bus8.bps_en, 0);
    check("t5_rst_rx_data", bus8.rx_data, 0);
    check("t5_rst_rx_done", bus8.rx_done, 0);
    check("t5_rst_rx_err", bus8.rx_err, 0);
    rst = 1'b0;
    idle(3 * bit_clks);
    check("t5_no_done", done8 - d0, 0);
    check("t5_no_err", err8 - e0, 0);
    send8(8'h81, 1'b1);
    idle(2 * bit_clks);
    check("t5_done_cnt", done8 - d0, 1);
    check("t5_rx_data", bus8.rx_data, 8'h81);

    // Test 6: 7-bit receiver, 7'h5A
    d0 = done7; e0 = err7; t0 = ticks7;
    send7(7'h5A);
    idle(2 * bit_clks);
    check("t6_done_cnt", done7 - d0, 1);
    check("t6_err_cnt", err7 - e0, 0);
    check("t6_rx_data", bus7.rx_data, 7'h5A);
    check("t6_ticks", ticks7 - t0, 9);
    check("t6_bps_en_low", bus7.bps_en, 0);

    check("done_err_overlap", both, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001: Parameter DATA_WIDTH, default 8, is the number of data bits per frame; legal range 5..8.
REQ-002: Port clk, input, 1, is the system clock; all logic SHALL be on its rising edge.
REQ-003: Port rst, input, 1, SHALL be an asynchronous, active-high reset.
REQ-004: Port rs232_rx, input, 1, is the asynchronous serial line; it idles high.
REQ-005: Port bps_clk, input, 1, is a one-cycle pulse from the baud generator at each bit's mid-point.
REQ-006: Port bps_en, output, 1, SHALL enable the baud generator while a frame is being received.
REQ-007: Port rx_data, output, DATA_WIDTH, SHALL hold the last correctly framed byte.
REQ-008: Port rx_done, output, 1, SHALL be a one-cycle pulse marking that rx_data has been updated.
REQ-009: Port rx_err, output, 1, SHALL be a one-cycle pulse marking a framing error (stop bit sampled low).

Function
REQ-010: rs232_rx SHALL pass through a 2-flop synchronizer, plus a third flop used for edge detection.
REQ-011: A falling edge SHALL be when the previous synchronized sample is 1 and the current one is 0.
REQ-012: The state machine SHALL have states IDLE and RECV, plus a bit counter bit_cnt sized for 0..DATA_WIDTH+1.
REQ-013: In IDLE, a detected falling edge SHALL set bps_en=1 on the next clk edge, clear bit_cnt, and enter RECV.
REQ-014: In RECV, each bps_clk pulse SHALL sample the synchronized line and then increment bit_cnt.
REQ-015: Pulse index 0 is the start bit; if it samples 1 (a glitch), the block SHALL return to IDLE with bps_en=0, no rx_done and no rx_err.
REQ-016: Pulse indices 1..DATA_WIDTH SHALL shift data bits into a shift register LSB first; rx_data SHALL NOT change during this.
REQ-017: Pulse index DATA_WIDTH+1 is the stop bit; on the following clk edge bps_en SHALL drop to 0 and the state SHALL go to IDLE.
REQ-018: If the stop bit samples 1, rx_data SHALL load the shift register and rx_done SHALL pulse high for exactly one cycle on that same edge.
REQ-019: If the stop bit samples 0, rx_err SHALL pulse for one cycle and rx_data SHALL keep its previous value.
REQ-020: Falling edges seen while in RECV SHALL be ignored.
REQ-021: bps_clk pulses seen while in IDLE SHALL be ignored.
REQ-022: A new frame SHALL be accepted on any falling edge detected after the return to IDLE, so back-to-back frames with one stop bit are received.
REQ-023: rx_done and rx_err SHALL never be high in the same cycle.
REQ-024: bps_en SHALL be a registered output that stays high continuously from the start of a frame to its end.

Reset
REQ-025: While rst=1, the block SHALL force state=IDLE, bps_en=0, rx_data=0, rx_done=0, rx_err=0, bit_cnt=0, shift register=0, and synchronizer flops=1.
REQ-026: Asserting rst mid-frame SHALL abort the frame immediately with no rx_done or rx_err; after release, the next falling edge starts a fresh frame.

Verification
REQ-027: Test 1. Stimulus: 12 MHz clk, baud generator at 1250 clocks/bit, send 0xA5 with a stop bit of 1. Response: exactly one rx_done, rx_data=8'hA5, bps_en high for about 10 bit periods and then low.
REQ-028: Test 2. Stimulus: send 0x3C with the stop bit driven 0. Response: one rx_err pulse, no rx_done, rx_data unchanged from 8'hA5.
REQ-029: Test 3. Stimulus: a 200-clock low glitch on an idle line. Response: bps_en rises and then falls after the start sample; no rx_done and no rx_err.
REQ-030: Test 4. Stimulus: send 0x00 and then 0xFF back to back with no idle gap. Response: two rx_done pulses, carrying 8'h00 and then 8'hFF.
REQ-031: Test 5. Stimulus: pulse rst during data bit 4 of 0x55. Response: all outputs go to their reset values; no rx_done; a following 0x81 is received correctly.
REQ-032: Test 6. Stimulus: DATA_WIDTH=7, send 7'h5A. Response: rx_done with rx_data=7'h5A, and the frame ends after 9 bps_clk pulses.
